// File: rtl/mips_cycle_controller.sv
// mips_cycle_controller
//   Multi-cycle sequencer for the MIPS core. Each pass fetches one instruction,
//   holds it while the combinational ALU/decoder settles, optionally runs the
//   data-memory handshake, then commits the register write and PC update in a
//   single writeback cycle.
//
// Ports
//   clk, rst_n          core clock (rising edge), asynchronous active-low reset
//   imem_req/addr       instruction fetch request and address (= pc)
//   imem_ack/rdata      fetch completion and instruction word
//   instr, pc           latched instruction and current PC, to the ALU
//   alu_pc_next         next PC from the ALU (word-aligned on commit)
//   alu_we_register     ALU requests a register write
//   alu_we_memory       ALU requests a data-memory access
//   rf_we               register-file write strobe, WB cycle only
//   dmem_req/ack        data-memory handshake
//   halt_req, halted    stop request (sampled in WB) and halted status
//   state               FSM state, for debug
//   retire_count        retired-instruction counter (wraps silently)
module mips_cycle_controller #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] alu_pc_next,
    input  logic                 alu_we_register,
    input  logic                 alu_we_memory,
    output logic                 rf_we,
    output logic                 dmem_req,
    input  logic                 dmem_ack,
    input  logic                 halt_req,
    output logic                 halted,
    output logic [2:0]           state,
    output logic [WORD_SIZE-1:0] retire_count
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic [WORD_SIZE-1:0] retire_q, retire_d;

    // The low PC bits are discarded on commit so the PC stays word-aligned.
    logic unused_pc_bits;
    assign unused_pc_bits = ^alu_pc_next[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = alu_we_memory ? MEM : WB;
            end
            MEM: begin
                if (dmem_ack) begin
                    state_d = WB;
                end
            end
            WB: begin
                pc_d     = {alu_pc_next[WORD_SIZE-1:2], 2'b00};
                retire_d = retire_q + {{(WORD_SIZE-1){1'b0}}, 1'b1};
                state_d  = halt_req ? HALT : FETCH;
            end
            HALT: begin
                if (!halt_req) begin
                    state_d = FETCH;
                end
            end
            // Codes 5-7 recover to FETCH without touching pc/instr.
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Handshake strobes depend only on the state register, so an async reset
    // drops any outstanding request immediately.
    assign imem_req     = (state_q == FETCH);
    assign dmem_req     = (state_q == MEM);
    assign rf_we        = (state_q == WB) && alu_we_register;
    assign halted       = (state_q == HALT);
    assign state        = state_q;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign instr        = instr_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_mips_cycle_controller.sv
module tb_mips_cycle_controller;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu_pc_next;
    logic        alu_we_register;
    logic        alu_we_memory;
    logic        rf_we;
    logic        dmem_req;
    logic        dmem_ack;
    logic        halt_req;
    logic        halted;
    logic [2:0]  state;
    logic [31:0] retire_count;

    // Narrow instance used to reach the retire counter wrap in few cycles.
    logic       s_rst_n;
    logic       s_imem_req;
    logic [3:0] s_imem_addr;
    logic [3:0] s_instr;
    logic [3:0] s_pc;
    logic       s_rf_we;
    logic       s_dmem_req;
    logic       s_halted;
    logic [2:0] s_state;
    logic [3:0] s_retire;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mips_cycle_controller #(.WORD_SIZE(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .pc(pc),
        .alu_pc_next(alu_pc_next),
        .alu_we_register(alu_we_register), .alu_we_memory(alu_we_memory),
        .rf_we(rf_we), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .halt_req(halt_req), .halted(halted), .state(state),
        .retire_count(retire_count)
    );

    mips_cycle_controller #(.WORD_SIZE(4), .RESET_PC(4'h0)) u_small (
        .clk(clk), .rst_n(s_rst_n),
        .imem_req(s_imem_req), .imem_addr(s_imem_addr),
        .imem_ack(1'b1), .imem_rdata(4'h5),
        .instr(s_instr), .pc(s_pc),
        .alu_pc_next(4'h7),
        .alu_we_register(1'b1), .alu_we_memory(1'b0),
        .rf_we(s_rf_we), .dmem_req(s_dmem_req), .dmem_ack(1'b0),
        .halt_req(1'b0), .halted(s_halted), .state(s_state),
        .retire_count(s_retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total_cnt++; if (state !== 3'd0) $display("FAIL reset_state got %0d exp 0", state); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL reset_pc got %h exp 0", pc); else pass_cnt++;
        total_cnt++; if (instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'h0) $display("FAIL reset_retire got %h exp 0", retire_count); else pass_cnt++;
        total_cnt++; if ({rf_we, dmem_req, halted} !== 3'b000) $display("FAIL reset_strobes got %b exp 000", {rf_we, dmem_req, halted}); else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (imem_req !== 1'b1) $display("FAIL reset_imem_req got %b exp 1", imem_req); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_imem_addr got %h exp 0", imem_addr); else pass_cnt++;
    endtask

    task automatic test_add();
        imem_ack = 1'b1; imem_rdata = 32'h012A4020;
        alu_pc_next = 32'h4; alu_we_register = 1'b1; alu_we_memory = 1'b0;
        // cycle 1: FETCH with immediate ack
        total_cnt++; if (state !== 3'd0 || rf_we !== 1'b0) $display("FAIL add_c1 got state=%0d rf_we=%b exp 0/0", state, rf_we); else pass_cnt++;
        tick();
        imem_ack = 1'b0;
        // cycle 2: EXEC
        total_cnt++; if (state !== 3'd1 || rf_we !== 1'b0) $display("FAIL add_c2 got state=%0d rf_we=%b exp 1/0", state, rf_we); else pass_cnt++;
        total_cnt++; if (instr !== 32'h012A4020) $display("FAIL add_instr got %h exp 012a4020", instr); else pass_cnt++;
        tick();
        // cycle 3: WB
        total_cnt++; if (state !== 3'd3 || rf_we !== 1'b1) $display("FAIL add_c3 got state=%0d rf_we=%b exp 3/1", state, rf_we); else pass_cnt++;
        total_cnt++; if (pc !== 32'h0) $display("FAIL add_c3_pc got %h exp 0", pc); else pass_cnt++;
        tick();
        // cycle 4: back in FETCH with committed PC
        total_cnt++; if (state !== 3'd0 || rf_we !== 1'b0) $display("FAIL add_c4 got state=%0d rf_we=%b exp 0/0", state, rf_we); else pass_cnt++;
        total_cnt++; if (pc !== 32'h4) $display("FAIL add_pc got %h exp 4", pc); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'h1) $display("FAIL add_retire got %0d exp 1", retire_count); else pass_cnt++;
    endtask

    task automatic test_fetch_wait();
        int held;
        held = 0;
        imem_ack = 1'b0; imem_rdata = 32'hDEADBEEF;
        alu_pc_next = 32'h8; alu_we_register = 1'b1; alu_we_memory = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h4 && state === 3'd0) held++;
            tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'h8D090004;
        if (imem_req === 1'b1 && imem_addr === 32'h4 && state === 3'd0) held++;
        total_cnt++; if (held !== 6) $display("FAIL fetch_wait_held got %0d exp 6", held); else pass_cnt++;
        total_cnt++; if (instr !== 32'h012A4020) $display("FAIL fetch_wait_instr_early got %h exp 012a4020", instr); else pass_cnt++;
        tick();
        // EXEC: a stray imem_ack here must not reload instr
        imem_rdata = 32'hFFFFFFFF;
        total_cnt++; if (state !== 3'd1 || instr !== 32'h8D090004) $display("FAIL fetch_wait_latch got state=%0d instr=%h exp 1/8d090004", state, instr); else pass_cnt++;
        tick();
        imem_ack = 1'b0;
        total_cnt++; if (state !== 3'd3 || instr !== 32'h8D090004) $display("FAIL fetch_wait_wb got state=%0d instr=%h exp 3/8d090004", state, instr); else pass_cnt++;
        tick();
        total_cnt++; if (pc !== 32'h8 || retire_count !== 32'h2) $display("FAIL fetch_wait_commit got pc=%h ret=%0d exp 8/2", pc, retire_count); else pass_cnt++;
    endtask

    task automatic test_store();
        int cycles;
        int mem_cycles;
        cycles = 0; mem_cycles = 0;
        imem_ack = 1'b1; imem_rdata = 32'hAD090000;
        alu_pc_next = 32'hC; alu_we_register = 1'b0; alu_we_memory = 1'b1;
        dmem_ack = 1'b0;
        while (state !== 3'd0 || cycles == 0) begin
            if (cycles > 20) break;
            if (state === 3'd2) begin
                mem_cycles++;
                dmem_ack = (mem_cycles == 3);
                if (dmem_req !== 1'b1) $display("FAIL store_dmem_req got %b exp 1", dmem_req);
            end else begin
                dmem_ack = 1'b0;
            end
            if (state === 3'd3) begin
                total_cnt++; if (rf_we !== 1'b0) $display("FAIL store_rf_we got %b exp 0", rf_we); else pass_cnt++;
            end
            cycles++;
            tick();
            imem_ack = 1'b0;
        end
        dmem_ack = 1'b0;
        total_cnt++; if (mem_cycles !== 3) $display("FAIL store_mem_cycles got %0d exp 3", mem_cycles); else pass_cnt++;
        total_cnt++; if (cycles !== 6) $display("FAIL store_total_cycles got %0d exp 6", cycles); else pass_cnt++;
        total_cnt++; if (pc !== 32'hC || retire_count !== 32'h3) $display("FAIL store_commit got pc=%h ret=%0d exp c/3", pc, retire_count); else pass_cnt++;
    endtask

    task automatic test_halt();
        imem_ack = 1'b1; imem_rdata = 32'h012A4020;
        alu_pc_next = 32'h10; alu_we_register = 1'b1; alu_we_memory = 1'b0;
        tick();
        imem_ack = 1'b0;
        halt_req = 1'b1;
        tick();
        total_cnt++; if (state !== 3'd3 || rf_we !== 1'b1 || halted !== 1'b0) $display("FAIL halt_wb got state=%0d rf_we=%b halted=%b exp 3/1/0", state, rf_we, halted); else pass_cnt++;
        tick();
        total_cnt++; if (state !== 3'd4 || halted !== 1'b1) $display("FAIL halt_enter got state=%0d halted=%b exp 4/1", state, halted); else pass_cnt++;
        total_cnt++; if (pc !== 32'h10 || retire_count !== 32'h4) $display("FAIL halt_commit got pc=%h ret=%0d exp 10/4", pc, retire_count); else pass_cnt++;
        total_cnt++; if (imem_req !== 1'b0 || dmem_req !== 1'b0) $display("FAIL halt_reqs got imem=%b dmem=%b exp 0/0", imem_req, dmem_req); else pass_cnt++;
        tick();
        total_cnt++; if (state !== 3'd4 || pc !== 32'h10) $display("FAIL halt_hold got state=%0d pc=%h exp 4/10", state, pc); else pass_cnt++;
        halt_req = 1'b0;
        tick();
        total_cnt++; if (state !== 3'd0 || halted !== 1'b0 || imem_addr !== 32'h10) $display("FAIL halt_resume got state=%0d halted=%b addr=%h exp 0/0/10", state, halted, imem_addr); else pass_cnt++;
    endtask

    task automatic test_misalign();
        imem_ack = 1'b1; imem_rdata = 32'h012A4020;
        alu_pc_next = 32'h13; alu_we_register = 1'b1; alu_we_memory = 1'b0;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        total_cnt++; if (pc !== 32'h10) $display("FAIL misalign_pc got %h exp 10", pc); else pass_cnt++;
        total_cnt++; if (retire_count !== 32'h5) $display("FAIL misalign_retire got %0d exp 5", retire_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid_mem();
        imem_ack = 1'b1; imem_rdata = 32'hAD090000;
        alu_pc_next = 32'h14; alu_we_register = 1'b1; alu_we_memory = 1'b1;
        dmem_ack = 1'b0;
        tick();
        imem_ack = 1'b0;
        tick();
        total_cnt++; if (state !== 3'd2 || dmem_req !== 1'b1) $display("FAIL rstmem_in_mem got state=%0d dmem_req=%b exp 2/1", state, dmem_req); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (dmem_req !== 1'b0 || rf_we !== 1'b0) $display("FAIL rstmem_drop got dmem_req=%b rf_we=%b exp 0/0", dmem_req, rf_we); else pass_cnt++;
        total_cnt++; if (state !== 3'd0 || pc !== 32'h0 || retire_count !== 32'h0) $display("FAIL rstmem_regs got state=%0d pc=%h ret=%0d exp 0/0/0", state, pc, retire_count); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || state !== 3'd0) $display("FAIL rstmem_release got req=%b addr=%h state=%0d exp 1/0/0", imem_req, imem_addr, state); else pass_cnt++;
    endtask

    task automatic test_wrap();
        s_rst_n = 1'b1;
        tick();
        for (int i = 0; i < 45; i++) tick();
        total_cnt++; if (s_retire !== 4'hF) $display("FAIL wrap_pre got %h exp f", s_retire); else pass_cnt++;
        total_cnt++; if (s_pc !== 4'h4) $display("FAIL wrap_pc got %h exp 4", s_pc); else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++; if (s_retire !== 4'h0) $display("FAIL wrap_post got %h exp 0", s_retire); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; s_rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; alu_pc_next = '0;
        alu_we_register = 1'b0; alu_we_memory = 1'b0;
        dmem_ack = 1'b0; halt_req = 1'b0;
        test_reset();
        test_add();
        test_fetch_wait();
        test_store();
        test_halt();
        test_misalign();
        test_reset_mid_mem();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
